seg_rr_arbiter: RTL
===================

Name: seg_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8-way encoder/7-segment display resource among 8 requesters.
- Grants one requester at a time and holds the grant until that requester signals done, drops its request, or a hold timeout expires.
- Outputs the granted index as binary, as a one-hot vector, and as an active-low 7-segment code for the board HEX digit.
- Sits between the requester logic and the display, replacing the fixed-priority 8-3 encoder path.

Parameters:
- MAX_HOLD, 16, maximum BUSY cycles per grant before forced release; legal range 2..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- en  input  1  arbiter enable.
- req  input  8  request vector; bit i = requester i.
- done  input  1  one-cycle release pulse from the currently granted requester.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.
- HEX  output  8  active-low segments {a,b,c,d,e,f,g,dp}, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ptr=0, cnt=0.
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, HEX=8'hFF.
  - Reset overrides everything, including mid-grant; no timeout pulse is generated.
- States:
  - IDLE, BUSY and REST.
  - All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - If en=1 and req!=0: scan req from bit ptr upward, wrapping 7->0; the first set bit k wins.
  - Next cycle: gnt=1<<k, gnt_idx=k, gnt_valid=1, cnt=0, state=BUSY.
  - Otherwise stay in IDLE with outputs idle.
  - Latency: req sampled at edge t gives the grant visible after edge t+1.
- BUSY: release occurs at the edge where any of the following holds.
  - (a) done=1.
  - (b) req[gnt_idx]=0.
  - (c) en=0.
  - (d) cnt==MAX_HOLD-1.
- BUSY, no release: cnt increments; outputs hold.
- On release:
  - state=REST; gnt=0, gnt_valid=0, gnt_idx holds its last value.
  - ptr=(gnt_idx+1) mod 8; HEX=8'hFF.
- Timeout pulse:
  - timeout=1 for exactly the REST cycle, only when (d) is the sole cause.
  - If done, a request drop or en=0 coincides with (d), release is normal and timeout stays 0.
- REST:
  - One mandatory idle cycle, then IDLE unconditionally.
  - Timing: done at edge t gives grant low after t+1, IDLE after t+2, earliest new grant after t+3.
- done: ignored in IDLE and REST.
- HEX:
  - Updated on the same edge as gnt_valid.
  - When gnt_valid=1, HEX = code(gnt_idx) with codes 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F (hex).
  - When gnt_valid=0, HEX=FF.
- Fairness: a continuously requesting requester is granted within 7 intervening grants.
- Counter:
  - cnt never exceeds MAX_HOLD-1 and has no wrap-around.
  - ptr wraps 7->0 modulo 8.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=FF, en=1 -> gnt=00, gnt_valid=0, HEX=FF, timeout=0 throughout; after release, grant to idx 0 one cycle later.
- Round-robin: req=8'b1000_0101 held, done pulsed 1 cycle after each grant -> grant sequence idx 0,2,7,0; HEX sequence 03,25,1F,03; one REST cycle (gnt=00, HEX=FF) between grants.
- Timeout: MAX_HOLD=4, req=02 held, no done -> gnt=02 for exactly 4 cycles; timeout=1 during the following REST cycle; regrant idx 1 after IDLE.
- Coincident done and timeout: MAX_HOLD=4, done on 4th BUSY cycle -> release with timeout=0.
- Request drop and enable: granted idx 5, req[5] cleared -> gnt=00 next cycle. Separately, en=0 in BUSY -> release. en=0 with req=FF in IDLE -> no grant, HEX=FF.
- Mid-grant reset: grant idx 6 active, then rst_n=0 -> gnt=00, ptr=0; with req=C1 the next grant is idx 0, not idx 7.

Source files
------------

// File: rtl/seg_rr_arbiter.sv
// Round-robin arbiter sharing one HEX display digit among 8 requesters.
// Grants are held until done, request drop, disable or a MAX_HOLD timeout.
module seg_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [7:0] HEX
);

  typedef enum logic [1:0] {IDLE, BUSY, REST} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [2:0] win_idx;
  logic       win_found;
  logic       hold_hit;
  logic       early_rel;

  // Active-low segment codes {a,b,c,d,e,f,g,dp} for digits 0..7.
  function automatic logic [7:0] seg_code(input logic [2:0] idx);
    case (idx)
      3'd0:    seg_code = 8'h03;
      3'd1:    seg_code = 8'h9F;
      3'd2:    seg_code = 8'h25;
      3'd3:    seg_code = 8'h0D;
      3'd4:    seg_code = 8'h99;
      3'd5:    seg_code = 8'h49;
      3'd6:    seg_code = 8'h41;
      default: seg_code = 8'h1F;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [2:0] cand;
    win_idx   = ptr;
    win_found = 1'b0;
    cand      = ptr;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign hold_hit  = (cnt == CNT_W'(MAX_HOLD - 1));
  assign early_rel = done || !req[gnt_idx] || !en;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      HEX       <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (en && win_found) begin
            state     <= BUSY;
            gnt       <= 8'h01 << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            HEX       <= seg_code(win_idx);
          end
        end
        BUSY: begin
          if (early_rel || hold_hit) begin
            state     <= REST;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            HEX       <= 8'hFF;
            // Flag a forced release only when nothing else asked for it.
            timeout   <= hold_hit && !early_rel;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
